// File: rtl/wtch_uart_sender.sv
// Watch-bus to UART text framer: snapshots the time and streams "HH:MM:SS.CC\r\n".
// Optional macro WTCH_UART_AUTO_SEND_EN starts a frame whenever the seconds field changes.
module wtch_uart_sender #(
    parameter logic [7:0] SEP_CHAR  = 8'h3A,
    parameter logic [7:0] FRAC_CHAR = 8'h2E,
    parameter logic [6:0] CLAMP_VAL = 7'd99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [23:0] wtch_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd12;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic        start;

    logic [15:0] hh_chars;
    logic [15:0] mm_chars;
    logic [15:0] ss_chars;
    logic [15:0] cc_chars;

    // Clamp a field and return its two ASCII decimal digits {tens, ones}.
    function automatic logic [15:0] two_dig(input logic [6:0] v);
        logic [6:0] c;
        logic [6:0] t;
        logic [6:0] o;
        c = (v > CLAMP_VAL) ? CLAMP_VAL : v;
        t = c / 7'd10;
        o = c % 7'd10;
        return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, o}};
    endfunction

`ifdef WTCH_UART_AUTO_SEND_EN
    logic [5:0] last_sec_q, last_sec_d;

    // A frame starts on request or when seconds differ from the last sent value.
    always_comb begin
        start      = send_req || (wtch_data[12:7] != last_sec_q);
        last_sec_d = last_sec_q;
        if (state_q == IDLE && start) begin
            last_sec_d = wtch_data[12:7];
        end
    end

    // Last-sent seconds register; 6'h3F never matches a legal value after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sec_q <= 6'h3F;
        end else begin
            last_sec_q <= last_sec_d;
        end
    end
`else
    // Frames start only on an explicit request.
    always_comb begin
        start = send_req;
    end
`endif

    // State, byte index and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            snap_q  <= 24'h000000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        tx_valid   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = wtch_data;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit pairs are derived from the snapshot, never from the live bus.
    always_comb begin
        hh_chars = two_dig({2'b00, snap_q[23:19]});
        mm_chars = two_dig({1'b0, snap_q[18:13]});
        ss_chars = two_dig({1'b0, snap_q[12:7]});
        cc_chars = two_dig(snap_q[6:0]);
    end

    // Select the frame byte for the current index; zero outside a frame.
    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) begin
            unique case (idx_q)
                4'd0:    tx_data = hh_chars[15:8];
                4'd1:    tx_data = hh_chars[7:0];
                4'd2:    tx_data = SEP_CHAR;
                4'd3:    tx_data = mm_chars[15:8];
                4'd4:    tx_data = mm_chars[7:0];
                4'd5:    tx_data = SEP_CHAR;
                4'd6:    tx_data = ss_chars[15:8];
                4'd7:    tx_data = ss_chars[7:0];
                4'd8:    tx_data = FRAC_CHAR;
                4'd9:    tx_data = cc_chars[15:8];
                4'd10:   tx_data = cc_chars[7:0];
                4'd11:   tx_data = 8'h0D;
                4'd12:   tx_data = 8'h0A;
                default: tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_wtch_uart_sender.sv
// Bench for wtch_uart_sender: table vectors plus random frames checked
// against a text-formatting reference model.
module tb_wtch_uart_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_req;
    logic [23:0] wtch_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_done;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        int    h;
        int    m;
        int    s;
        int    ms;
        int    mode;
        int    chg;
        int    xreq;
        string txt;
    } vec_t;

    vec_t vecs[7];

    wtch_uart_sender dut (
        .clk        (clk),
        .rst        (rst),
        .send_req   (send_req),
        .wtch_data  (wtch_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic string model(input int h, input int m,
                                    input int s, input int ms);
        return $sformatf("%02d:%02d:%02d.%02d", clampv(h), clampv(m),
                         clampv(s), clampv(ms));
    endfunction

    function automatic vec_t mk(input int h, input int m, input int s,
                                input int ms, input int mode, input int chg,
                                input int xreq, input string txt);
        vec_t v;
        v.h = h; v.m = m; v.s = s; v.ms = ms;
        v.mode = mode; v.chg = chg; v.xreq = xreq; v.txt = txt;
        return v;
    endfunction

    // Sends one frame; rst_at >= 0 aborts with reset when that byte is due.
    task automatic run_frame(input vec_t v, input int rst_at);
        logic [23:0] d;
        logic [7:0]  want;
        logic [7:0]  prev;
        bit          stalled;
        int          got;
        int          cyc;
        d = {v.h[4:0], v.m[5:0], v.s[5:0], v.ms[6:0]};
        @(negedge clk);
        wtch_data = d;
        send_req  = 1'b1;
        tx_ready  = 1'b0;
        @(negedge clk);
        send_req = 1'b0;
        got      = 0;
        cyc      = 0;
        stalled  = 1'b0;
        prev     = 8'h00;
        while (got < 13 && cyc < 300) begin
            if (rst_at == got) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valid", {31'd0, tx_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, frame_done}, 32'd0);
                chk("rst_data", {24'd0, tx_data}, 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_nodone", {31'd0, frame_done}, 32'd0);
                    chk("rst_novalid", {31'd0, tx_valid}, 32'd0);
                end
                return;
            end
            case (v.mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            send_req = (v.xreq == cyc);
            if (v.chg == got) wtch_data = 24'($urandom);
            if (got < 11) want = v.txt[got];
            else if (got == 11) want = 8'h0D;
            else want = 8'h0A;
            chk("valid", {31'd0, tx_valid}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            if (stalled) chk("hold", {24'd0, tx_data}, {24'd0, prev});
            if (tx_ready) begin
                chk($sformatf("byte%0d", got), {24'd0, tx_data},
                    {24'd0, want});
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev    = tx_data;
            end
            @(negedge clk);
            cyc++;
        end
        send_req = 1'b0;
        chk("count", got, 13);
        if (v.mode == 0) chk("latency", cyc, 13);
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_valid", {31'd0, tx_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_once", {31'd0, frame_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra", {31'd0, tx_valid}, 32'd0);
        end
    endtask

    initial begin
        int h, m, s, ms;
        vecs[0] = mk(12, 34, 56, 78, 0, -1, -1, "12:34:56.78");
        vecs[1] = mk(12, 34, 56, 78, 1, -1, -1, "12:34:56.78");
        vecs[2] = mk(12, 34, 56, 78, 0, 3, 5, "12:34:56.78");
        vecs[3] = mk(31, 63, 0, 120, 0, -1, -1, "31:63:00.99");
        vecs[4] = mk(0, 0, 0, 0, 2, 1, -1, "00:00:00.00");
        vecs[5] = mk(9, 5, 59, 99, 1, 7, 2, "09:05:59.99");
        vecs[6] = mk(23, 59, 59, 100, 2, -1, 9, "23:59:59.99");

        rst       = 1'b1;
        send_req  = 1'b0;
        tx_ready  = 1'b0;
        wtch_data = 24'h000000;
        repeat (2) @(negedge clk);
        chk("reset_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_data", {24'd0, tx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], -1);

        run_frame(vecs[0], 6);
        run_frame(vecs[0], -1);

        for (int i = 0; i < 12; i++) begin
            h  = $urandom_range(0, 31);
            m  = $urandom_range(0, 63);
            s  = $urandom_range(0, 63);
            ms = $urandom_range(0, 127);
            run_frame(mk(h, m, s, ms, $urandom_range(0, 2),
                         $urandom_range(0, 12), $urandom_range(1, 12),
                         model(h, m, s, ms)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
